// File: rtl/jam_pkg.sv
// Shared types and helpers for the exhaustive job-assignment engine.
package jam_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEval,
        StRev,
        StDone
    } state_e;

    // Ceiling log2 that can be evaluated at elaboration time.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor analysis: finds the pivot and the swap partner.
module jam_next_perm #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N*IW-1:0] perm_i,
    output logic            has_pivot_o,
    output logic [IW-1:0]   pivot_o,
    output logic [IW-1:0]   succ_o
);

    logic [N-1:0][IW-1:0] v;

    assign v = perm_i;

    // Pivot is the last ascent; partner is the rightmost larger element after it.
    always_comb begin
        has_pivot_o = 1'b0;
        pivot_o     = '0;
        succ_o      = '0;
        for (int p = 0; p < int'(N) - 1; p++) begin
            if (v[p] < v[p+1]) begin
                has_pivot_o = 1'b1;
                pivot_o     = IW'(p);
            end
        end
        // The suffix after the pivot is descending, so the rightmost larger value is the smallest.
        for (int i = 0; i < int'(N); i++) begin
            if (i > int'(pivot_o) && v[i] > v[pivot_o]) begin
                succ_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/jam_perm_search.sv
// Exhaustive N-worker/N-job assignment search over all permutations in lexicographic order.
module jam_perm_search
    import jam_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 7,
    parameter int unsigned IW = 3,
    parameter int unsigned SW = 10,
    parameter int unsigned MW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic            mode,
    output logic [IW-1:0]   W,
    output logic [IW-1:0]   J,
    input  logic [CW-1:0]   Cost,
    output logic            busy,
    output logic            Valid,
    output logic [SW-1:0]   BestCost,
    output logic [MW-1:0]   MatchCount,
    output logic [N*IW-1:0] BestPerm
);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("jam_perm_search: N must be in 2..8");
    end
    if (clog2(N) > IW) begin : g_bad_iw
        $error("jam_perm_search: IW too narrow for N");
    end
    if (SW < CW + clog2(N)) begin : g_bad_sw
        $error("jam_perm_search: SW too narrow for N costs");
    end

    function automatic logic [N-1:0][IW-1:0] identity_perm();
        logic [N-1:0][IW-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i] = IW'(i);
        return r;
    endfunction

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic                 first_q, first_d;
    logic [IW-1:0]        k_q, k_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [IW-1:0]        pivot_q, pivot_d;
    logic [N-1:0][IW-1:0] perm_q, perm_d;
    logic [IW-1:0]        w_q, w_d;
    logic [IW-1:0]        j_q, j_d;
    logic [SW-1:0]        best_q, best_d;
    logic [MW-1:0]        match_q, match_d;
    logic [N-1:0][IW-1:0] best_perm_q, best_perm_d;

    logic                 has_pivot;
    logic [IW-1:0]        pivot;
    logic [IW-1:0]        succ;
    logic [SW-1:0]        cost_ext;
    logic                 better;

    assign cost_ext = {{(SW - CW){1'b0}}, Cost};
    assign better   = mode_q ? (sum_q > best_q) : (sum_q < best_q);

    jam_next_perm #(
        .N  (N),
        .IW (IW)
    ) u_next_perm (
        .perm_i      (perm_q),
        .has_pivot_o (has_pivot),
        .pivot_o     (pivot),
        .succ_o      (succ)
    );

    // Next-state: sequencing, accumulation, best tracking and permutation stepping.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        first_d     = first_q;
        k_d         = k_q;
        sum_d       = sum_q;
        pivot_d     = pivot_q;
        perm_d      = perm_q;
        w_d         = w_q;
        j_d         = j_q;
        best_d      = best_q;
        match_d     = match_q;
        best_perm_d = best_perm_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    mode_d  = mode;
                    perm_d  = identity_perm();
                    sum_d   = '0;
                    k_d     = '0;
                    first_d = 1'b1;
                    w_d     = '0;
                    j_d     = '0;
                end
            end
            StFetch: begin
                sum_d = sum_q + cost_ext;
                if (k_q == IW'(N - 1)) begin
                    state_d = StEval;
                end else begin
                    k_d = k_q + 1'b1;
                    w_d = k_q + 1'b1;
                    j_d = perm_q[k_q + 1'b1];
                end
            end
            StEval: begin
                if (first_q || better) begin
                    best_d      = sum_q;
                    match_d     = {{(MW - 1){1'b0}}, 1'b1};
                    best_perm_d = perm_q;
                    first_d     = 1'b0;
                end else if (sum_q == best_q) begin
                    if (match_q != '1) match_d = match_q + 1'b1;
                end
                if (!has_pivot) begin
                    state_d = StDone;
                end else begin
                    perm_d[pivot] = perm_q[succ];
                    perm_d[succ]  = perm_q[pivot];
                    pivot_d       = pivot;
                    sum_d         = '0;
                    state_d       = StRev;
                end
            end
            StRev: begin
                for (int i = 0; i < int'(N); i++) begin
                    if (i > int'(pivot_q)) begin
                        perm_d[i] = perm_q[IW'(int'(N) + int'(pivot_q) - i)];
                    end
                end
                // Reversal never touches index 0, so the first job is already known.
                k_d     = '0;
                w_d     = '0;
                j_d     = perm_q[0];
                state_d = StFetch;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            first_q     <= 1'b0;
            k_q         <= '0;
            sum_q       <= '0;
            pivot_q     <= '0;
            perm_q      <= identity_perm();
            w_q         <= '0;
            j_q         <= '0;
            best_q      <= '0;
            match_q     <= '0;
            best_perm_q <= identity_perm();
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            first_q     <= first_d;
            k_q         <= k_d;
            sum_q       <= sum_d;
            pivot_q     <= pivot_d;
            perm_q      <= perm_d;
            w_q         <= w_d;
            j_q         <= j_d;
            best_q      <= best_d;
            match_q     <= match_d;
            best_perm_q <= best_perm_d;
        end
    end

    assign W          = w_q;
    assign J          = j_q;
    assign busy       = (state_q != StIdle);
    assign Valid      = (state_q == StDone);
    assign BestCost   = best_q;
    assign MatchCount = match_q;
    assign BestPerm   = best_perm_q;

endmodule

// File: doc/jam_perm_search.md
Name: jam_perm_search

Overview:
- Parametrised exhaustive job-assignment engine.
- Enumerates all N! worker→job permutations in lexicographic order and fetches each cost from an external combinational cost table over a W/J/Cost lookup port.
- Reports the best total cost, how many permutations reach it, and the first best permutation found.
- Supports a selectable minimise or maximise mode and a start/Valid handshake for repeated runs without reset.

Parameters:
- N, 8, number of workers = number of jobs (legal 2..8).
- CW, 7, Cost input width.
- IW, 3, index width; must satisfy 2^IW ≥ N.
- SW, 10, sum width; must be ≥ CW+ceil(log2 N).
- MW, 16, MatchCount width; saturating.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- mode  in  1  0 = minimise, 1 = maximise; latched when start is accepted.
- W  out  IW  worker index of current lookup.
- J  out  IW  job index of current lookup.
- Cost  in  CW  cost of (W,J); combinational from environment, valid in the same cycle.
- busy  out  1  high from start acceptance until the DONE cycle inclusive.
- Valid  out  1  one-cycle pulse; results are final.
- BestCost  out  SW  best total cost.
- MatchCount  out  MW  number of permutations equal to BestCost.
- BestPerm  out  N*IW  job of worker i at bits [i*IW +: IW].

Behaviour:
- Reset values:
  - W=0, J=0, busy=0, Valid=0, BestCost=0, MatchCount=0, BestPerm=identity.
  - State=IDLE, perm=identity.
- States: IDLE → FETCH → EVAL → REV → FETCH … ; EVAL → DONE → IDLE.
- IDLE:
  - start=1 → latch mode, perm=identity, sum=0, k=0, first=1; go to FETCH.
  - start is ignored in all other states.
- FETCH:
  - Cycle k (0..N-1) drives registered W=k, J=perm[k].
  - The edge ending the cycle adds zero-extended Cost into sum.
  - After k=N-1, go to EVAL.
- EVAL (single cycle), tot=sum:
  - Update best:
    - If first, or tot is better: BestCost=tot, MatchCount=1, BestPerm=perm, first=0.
    - Better means strictly less in mode 0, strictly greater in mode 1.
    - Else if tot==BestCost: MatchCount+1, saturating at all-ones. BestPerm unchanged, so the first lexicographic best is kept.
  - Next-permutation step:
    - pivot = largest p < N-1 with perm[p] < perm[p+1].
    - If no pivot exists (perm descending, last permutation) → DONE.
    - Else swap perm[pivot] with perm[s]. s is the rightmost index > pivot holding the smallest value greater than perm[pivot].
    - Clear sum, go to REV.
- REV:
  - Reverse perm[pivot+1..N-1] using the pivot registered in EVAL; go to FETCH with k=0.
- DONE: Valid=1 and busy=1 for this one cycle, then IDLE.
- Outputs hold until the next accepted start.
- BestCost/MatchCount/BestPerm are initialised only by the first EVAL of a run, not by start.
- Timing:
  - N+2 cycles per permutation; the last permutation takes N+1.
  - Valid is high exactly N!·(N+2) cycles after the accepting start edge.
- Arithmetic: no sum overflow by parameter constraint; MatchCount saturates.
- RST asserted mid-run: next edge restores all reset values; any partial results are discarded.
- start high together with RST: RST wins.
- W/J are don't-care outside FETCH but must remain stable (hold last value).

Decomposition:
- Package jam_pkg: state enum (IDLE, FETCH, EVAL, REV, DONE) and a clog2 function for parameter checks.
- Sub-module jam_next_perm: combinational.
  - Inputs: perm vector.
  - Outputs: has_pivot, pivot, succ index.
- Swap and reversal registers stay in the top module.

Test Plan:
- Uniform cost: N=3, Cost≡1, mode 0 → Valid at cycle 30 after start; BestCost=3, MatchCount=6, BestPerm={0,1,2}. W/J sequence for the second permutation is (0,0),(1,2),(2,1).
- Identity vs derangements: N=3, Cost=(W==J)?0:5.
  - mode 0 → BestCost=0, MatchCount=1, BestPerm={0,1,2}.
  - Rerun with start, mode 1 → BestCost=15, MatchCount=2, BestPerm={1,2,0}.
- Last-permutation winner: N=8 defaults, Cost=(J==7-W)?0:100, mode 0 → BestCost=0, MatchCount=1, BestPerm={7,6,5,4,3,2,1,0}, Valid exactly 403200 cycles after start.
- Saturation: N=3, MW=2, Cost≡1 → MatchCount=3, not wrapped.
- Control:
  - start pulses while busy → no restart; result identical to undisturbed run.
  - RST at cycle 12 of a run → next cycle all reset values, busy=0.
  - A fresh start then completes normally.
